adc_spi_responder: RTL and testbench
====================================

Name: adc_spi_responder

Overview:
- Device-side (slave) end of the serial ADC link: the behavioural/synthesizable model of the 10-bit SPI ADC that the ADC master drives.
- Decodes the 4-bit command frame on din (start, SGL/DIFF, ODD/SIGN, MSBF) and returns a null bit followed by a 10-bit conversion result on dout.
- Sits on the FPGA side for loopback/bring-up and as the bench responder for the master.
- Oversamples sclk/cs_n/din in the system clock domain.

Parameters:
- DATA_W, 10, conversion result width.
- SYNC_STAGES, 2, synchronizer flops on sclk, cs_n and din (minimum 2).

Ports:
- clk  input  1  system clock; all logic is rising-edge clk.
- rstc_n  input  1  asynchronous active-low reset.
- sclk  input  1  serial clock from master, asynchronous to clk.
- cs_n  input  1  chip select from master, active low.
- din  input  1  command bits from master.
- dout  output  1  result bits to master.
- dout_oe  output  1  dout drive enable; 0 means tri-stated at pad.
- sample_data  input  DATA_W  conversion value presented by the analog model/source.
- conv_req  output  1  one-clk pulse when the command is decoded and sample_data is captured.
- ch_sel  output  1  ODD/SIGN bit of the last decoded command.
- single_ended  output  1  SGL/DIFF bit of the last decoded command.
- frame_done  output  1  one-clk pulse when the last result bit has been driven.
- frame_err  output  1  one-clk pulse when cs_n rises before frame_done.

Behaviour:
- Reset, asynchronous:
  - dout=0, dout_oe=0, conv_req=0, ch_sel=0, single_ended=0, frame_done=0, frame_err=0.
  - State is IDLE and all synchronizers are cleared. Synchronizers reset to sclk=0, cs_n=1, din=0.
- Input sync and edge detect:
  - sclk, cs_n and din each pass through SYNC_STAGES flops.
  - An sclk rise is sync_prev=0 and sync=1; a fall is the reverse.
  - Master constraint: sclk high and low times are each at least SYNC_STAGES+2 clk periods.
- Output timing:
  - dout and dout_oe update on the clk after a detected sclk fall, so latency is SYNC_STAGES+1 clk from the pin edge.
  - The master samples dout on sclk rise.
- States:
  - IDLE: wait for cs_n low, then go to WAIT_START. While cs_n is high: dout_oe=0, dout=0.
  - WAIT_START: on each sclk rise, if din=1 go to CMD with bit counter 0; if din=0 stay (leading zeros are ignored).
  - CMD: on sclk rise, sample SGL, then ODD, then MSBF.
    - On the MSBF rise: latch sample_data into shift register sr, latch the mode bits, assert conv_req for 1 clk, update ch_sel/single_ended, go to NULL.
  - NULL: on the next sclk fall, dout_oe=1 and dout=0. Go to DATA_MSB with index 9.
  - DATA_MSB: on each sclk fall, drive dout=sr[index] from 9 down to 0.
    - After the fall that drives D0: if MSBF=1, go to DONE and pulse frame_done; if MSBF=0, go to DATA_LSB with index 1.
  - DATA_LSB: on each sclk fall after D0 has been held for one bit time, drive sr[1] up to sr[9]. After the fall that drives D9, pulse frame_done and go to DONE.
  - DONE: on later sclk falls, dout=0 and dout_oe stays 1 until cs_n rises.
- cs_n rising in any state except IDLE:
  - Return to IDLE next clk, with dout_oe=0 and dout=0.
  - frame_err pulses if frame_done has not yet pulsed for this frame.
  - This has priority over a simultaneous sclk edge.
- sr is updated only at conv_req. A sample_data change mid-frame does not affect the frame in progress.
- The bit counter is 4 bits and never wraps. Extra sclk edges in DONE are ignored.
- Reset asserted mid-frame: immediate return to the reset values. The next frame requires cs_n high then low.

Decomposition:
- Shared package adc_spi_pkg:
  - state enum (IDLE, WAIT_START, CMD, NULL, DATA_MSB, DATA_LSB, DONE);
  - ADC_DATA_W=10;
  - CMD_BITS=3;
  - the default compare threshold 10'h025 used by the master.
- One sub-module, adc_sync_edge: an N-stage synchronizer with rise/fall pulse outputs, instantiated for sclk, cs_n and din (din uses only the level).

Test Plan:
- cs_n low; din=1,1,0,1 on rises with sample_data=10'h2A5 -> conv_req 1 pulse, single_ended=1, ch_sel=0; dout after null = 1,0,1,0,1,0,0,1,0,1 then 0s; one frame_done pulse.
- Same frame with MSBF=0 and sample_data=10'h0F3 -> null, D9..D0 = 0011110011, then D1..D9 = 1,0,0,1,1,1,1,0,0; frame_done after D9.
- Two leading zeros on din before the start bit -> decode identical to scenario 1; dout_oe stays 0 until the null-bit fall.
- cs_n rises after 5 result bits -> frame_err 1 pulse, no frame_done, dout_oe=0 within SYNC_STAGES+1 clk.
- rstc_n low during DATA_MSB -> all outputs 0 immediately; the next full frame with sample_data=10'h026 returns 0000100110.
- sample_data changed from 10'h3FF to 10'h000 after conv_req -> dout still streams all ones for that frame.

Source files
------------

// File: rtl/adc_spi_pkg.sv
// Shared types and constants for the serial ADC link (master and responder).
package adc_spi_pkg;
  localparam int ADC_DATA_W = 10;
  localparam int CMD_BITS   = 3;
  localparam logic [ADC_DATA_W-1:0] DEF_THRESH = 10'h025;

  typedef enum logic [2:0] {
    IDLE, WAIT_START, CMD, NULL, DATA_MSB, DATA_LSB, DONE
  } state_t;
endpackage

// File: rtl/adc_sync_edge.sv
// N-flop synchronizer with registered-history edge pulses and a fill flag
// that goes high once the chain holds real pin samples after reset.
module adc_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall,
  output logic valid
);
  logic [STAGES-1:0] sync;
  logic              prev;
  logic [STAGES:0]   vld_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync     <= {STAGES{RST_VAL}};
      prev     <= RST_VAL;
      vld_pipe <= '0;
    end else begin
      sync     <= {sync[STAGES-2:0], pin};
      prev     <= sync[STAGES-1];
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
    end
  end

  assign level = sync[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;
  assign valid = vld_pipe[STAGES];
endmodule

// File: rtl/adc_spi_responder.sv
// Device side of the 10-bit SPI ADC: decodes start/SGL/ODD/MSBF on din and
// streams null + result (MSB first, optionally followed by LSB-first tail).
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int DATA_W      = ADC_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstc_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              din,
  output logic              dout,
  output logic              dout_oe,
  input  logic [DATA_W-1:0] sample_data,
  output logic              conv_req,
  output logic              ch_sel,
  output logic              single_ended,
  output logic              frame_done,
  output logic              frame_err
);
  logic sclk_rise, sclk_fall, cs_lvl, cs_rise, cs_vld, din_lvl;
  logic unused_sclk_lvl, unused_sclk_vld, unused_cs_fall;
  logic unused_din_rise, unused_din_fall, unused_din_vld;

  adc_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rstc_n), .pin(sclk), .level(unused_sclk_lvl),
    .rise(sclk_rise), .fall(sclk_fall), .valid(unused_sclk_vld));
  adc_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst_n(rstc_n), .pin(cs_n), .level(cs_lvl),
    .rise(cs_rise), .fall(unused_cs_fall), .valid(cs_vld));
  adc_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_din (
    .clk(clk), .rst_n(rstc_n), .pin(din), .level(din_lvl),
    .rise(unused_din_rise), .fall(unused_din_fall), .valid(unused_din_vld));

  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic [DATA_W-1:0] sr, sr_nx;
  logic              msbf, msbf_nx, sgl_q, sgl_nx, odd_q, odd_nx;
  logic              armed;
  logic              dout_nx, oe_nx, conv_nx, chs_nx, se_nx, done_nx, err_nx;
  logic              abort;

  // A frame only starts after cs_n has been seen high through a filled
  // synchronizer, so a reset with cs_n held low cannot begin a frame.
  assign abort = cs_rise && (state != IDLE);

  always_ff @(posedge clk or negedge rstc_n) begin
    if (!rstc_n) begin
      state        <= IDLE;
      cnt          <= '0;
      sr           <= '0;
      msbf         <= 1'b0;
      sgl_q        <= 1'b0;
      odd_q        <= 1'b0;
      armed        <= 1'b0;
      dout         <= 1'b0;
      dout_oe      <= 1'b0;
      conv_req     <= 1'b0;
      ch_sel       <= 1'b0;
      single_ended <= 1'b0;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      sr           <= sr_nx;
      msbf         <= msbf_nx;
      sgl_q        <= sgl_nx;
      odd_q        <= odd_nx;
      armed        <= armed | (cs_vld & cs_lvl);
      dout         <= dout_nx;
      dout_oe      <= oe_nx;
      conv_req     <= conv_nx;
      ch_sel       <= chs_nx;
      single_ended <= se_nx;
      frame_done   <= done_nx;
      frame_err    <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sr_nx    = sr;
    msbf_nx  = msbf;
    sgl_nx   = sgl_q;
    odd_nx   = odd_q;
    if (abort) state_nx = IDLE;
    else begin
      case (state)
        IDLE:       if (armed && !cs_lvl) state_nx = WAIT_START;
        WAIT_START: if (sclk_rise && din_lvl) begin
                      state_nx = CMD;
                      cnt_nx   = '0;
                    end
        CMD:        if (sclk_rise) begin
                      cnt_nx = cnt + 4'd1;
                      if (cnt == 4'd0) sgl_nx = din_lvl;
                      else if (cnt == 4'd1) odd_nx = din_lvl;
                      else begin
                        msbf_nx  = din_lvl;
                        sr_nx    = sample_data;
                        state_nx = NULL;
                      end
                    end
        NULL:       if (sclk_fall) begin
                      state_nx = DATA_MSB;
                      cnt_nx   = 4'(DATA_W - 1);
                    end
        DATA_MSB:   if (sclk_fall) begin
                      if (cnt != 4'd0) cnt_nx = cnt - 4'd1;
                      else if (msbf) state_nx = DONE;
                      else begin
                        state_nx = DATA_LSB;
                        cnt_nx   = 4'd1;
                      end
                    end
        DATA_LSB:   if (sclk_fall) begin
                      if (cnt == 4'(DATA_W - 1)) state_nx = DONE;
                      else cnt_nx = cnt + 4'd1;
                    end
        default:    ;
      endcase
    end
  end

  always_comb begin
    dout_nx = dout;
    oe_nx   = dout_oe;
    conv_nx = 1'b0;
    chs_nx  = ch_sel;
    se_nx   = single_ended;
    done_nx = 1'b0;
    err_nx  = 1'b0;
    if (abort) begin
      dout_nx = 1'b0;
      oe_nx   = 1'b0;
      err_nx  = (state != DONE);
    end else begin
      case (state)
        IDLE:     begin dout_nx = 1'b0; oe_nx = 1'b0; end
        CMD:      if (sclk_rise && cnt >= 4'(CMD_BITS - 1)) begin
                    conv_nx = 1'b1;
                    chs_nx  = odd_q;
                    se_nx   = sgl_q;
                  end
        NULL:     if (sclk_fall) begin dout_nx = 1'b0; oe_nx = 1'b1; end
        DATA_MSB: if (sclk_fall) begin
                    dout_nx = sr[cnt];
                    done_nx = (cnt == 4'd0) && msbf;
                  end
        DATA_LSB: if (sclk_fall) begin
                    dout_nx = sr[cnt];
                    done_nx = (cnt == 4'(DATA_W - 1));
                  end
        DONE:     if (sclk_fall) dout_nx = 1'b0;
        default:  ;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed frames against a bit-stream model of what the master should see
// on each sclk rise, plus an idle-bus monitor checked every clk.
module tb_adc_spi_responder;
  localparam int SYNC = 2;
  localparam int HALF = 6;

  logic       clk = 1'b0, rstc_n = 1'b0, sclk = 1'b0, cs_n = 1'b1, din = 1'b0;
  logic [9:0] sample_data = '0;
  logic       dout, dout_oe, conv_req, ch_sel, single_ended, frame_done, frame_err;
  int         vectors = 0, miscompares = 0;
  int         n_conv = 0, n_done = 0, n_err = 0, cs_hi = 0;

  always #5 clk = ~clk;

  adc_spi_responder #(.DATA_W(10), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rstc_n(rstc_n), .sclk(sclk), .cs_n(cs_n), .din(din),
    .dout(dout), .dout_oe(dout_oe), .sample_data(sample_data),
    .conv_req(conv_req), .ch_sel(ch_sel), .single_ended(single_ended),
    .frame_done(frame_done), .frame_err(frame_err));

  always @(posedge clk) begin
    if (conv_req)   n_conv <= n_conv + 1;
    if (frame_done) n_done <= n_done + 1;
    if (frame_err)  n_err  <= n_err + 1;
    cs_hi <= cs_n ? cs_hi + 1 : 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  // {oe, dout} the master sees on result rise k (k=1 is the null bit).
  function automatic logic [1:0] exp_out(input logic [9:0] d, input logic msbf, input int k);
    if (k == 1)              return 2'b10;
    if (k <= 11)             return {1'b1, d[11-k]};
    if (!msbf && k <= 20)    return {1'b1, d[k-11]};
    return 2'b10;
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (cs_hi > SYNC + 2) check("idle_bus", {dout_oe, dout, conv_req}, 3'b000);
    end
  endtask

  // cmd = {sgl, odd, msbf}; stop_k>0 ends the frame after result rise stop_k.
  task automatic do_frame(input string tag, input logic [9:0] data, input logic [2:0] cmd,
                          input int lead, input int stop_k, input bit rst_abort,
                          input bit late, input logic [9:0] lit_word, input logic [8:0] lit_tail);
    int         base_c, base_d, base_e, nk;
    logic [9:0] word;
    logic [8:0] tail;
    logic [3:0] bits;
    logic [9:0] captured;
    base_c = n_conv; base_d = n_done; base_e = n_err;
    sample_data = data;
    captured    = data;
    bits        = {1'b1, cmd};
    word = '0; tail = '0;
    @(negedge clk);
    cs_n = 1'b0;
    for (int i = 0; i < lead + 4; i++) begin
      din = (i < lead) ? 1'b0 : bits[3 - (i - lead)];
      repeat (HALF) @(negedge clk);
      check($sformatf("%s_cmd%0d_quiet", tag, i), {dout_oe, dout}, 2'b00);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    if (late) sample_data = ~data;
    check($sformatf("%s_conv_req", tag), n_conv - base_c, 1);
    check($sformatf("%s_mode", tag), {single_ended, ch_sel}, {cmd[2], cmd[1]});
    nk = cmd[0] ? 14 : 22;
    if (stop_k > 0) nk = stop_k;
    for (int k = 1; k <= nk; k++) begin
      repeat (HALF) @(negedge clk);
      check($sformatf("%s_bit%0d", tag, k), {dout_oe, dout}, exp_out(captured, cmd[0], k));
      if (k >= 2 && k <= 11)  word = {word[8:0], dout};
      if (k >= 12 && k <= 20) tail = {tail[7:0], dout};
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    if (rst_abort) begin
      repeat (HALF) @(negedge clk);
      rstc_n = 1'b0;
      #1;
      check($sformatf("%s_async_rst", tag),
            {dout, dout_oe, conv_req, ch_sel, single_ended, frame_done, frame_err}, 7'b0);
      cs_n = 1'b1;
      repeat (4) @(negedge clk);
      rstc_n = 1'b1;
      repeat (8) @(negedge clk);
      return;
    end
    if (stop_k == 0) repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
    check($sformatf("%s_release", tag), {dout_oe, dout}, 2'b00);
    repeat (3) @(negedge clk);
    check($sformatf("%s_done_cnt", tag), n_done - base_d, (stop_k == 0) ? 1 : 0);
    check($sformatf("%s_err_cnt", tag), n_err - base_e, (stop_k == 0) ? 0 : 1);
    check($sformatf("%s_conv_cnt", tag), n_conv - base_c, 1);
    if (stop_k == 0) begin
      check($sformatf("%s_word", tag), word, lit_word);
      if (!cmd[0]) check($sformatf("%s_tail", tag), tail, lit_tail);
    end
    repeat (HALF) @(negedge clk);
  endtask

  initial begin
    #1;
    check("reset_outputs",
          {dout, dout_oe, conv_req, ch_sel, single_ended, frame_done, frame_err}, 7'b0);
    repeat (4) @(negedge clk);
    rstc_n = 1'b1;
    repeat (8) @(negedge clk);
    fork monitor(); join_none

    do_frame("msbf1",   10'h2A5, 3'b101, 0, 0, 1'b0, 1'b0, 10'h2A5, 9'h000);
    do_frame("msbf0",   10'h0F3, 3'b100, 0, 0, 1'b0, 1'b0, 10'h0F3, 9'b100111100);
    do_frame("lead0s",  10'h2A5, 3'b101, 2, 0, 1'b0, 1'b0, 10'h2A5, 9'h000);
    do_frame("diff_ch", 10'h155, 3'b011, 1, 0, 1'b0, 1'b0, 10'h155, 9'h000);
    do_frame("abort",   10'h2A5, 3'b101, 0, 6, 1'b0, 1'b0, 10'h000, 9'h000);
    do_frame("rst_mid", 10'h2A5, 3'b101, 0, 4, 1'b1, 1'b0, 10'h000, 9'h000);
    check("post_rst_outputs", {dout, dout_oe, ch_sel, single_ended}, 4'b0);
    do_frame("after_rst", 10'h026, 3'b101, 0, 0, 1'b0, 1'b0, 10'h026, 9'h000);
    do_frame("late_chg",  10'h3FF, 3'b101, 0, 0, 1'b0, 1'b1, 10'h3FF, 9'h000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
